// File: rtl/exe_pkg.sv
// Shared types and constants for the EXE arbiter: FSM states, ALU opcodes
// and CPSR flag bit positions.
package exe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;
  localparam logic [2:0] ALU_MVN = 3'd6;
  localparam logic [2:0] ALU_NOP = 3'd7;

  localparam int CPSR_N = 31;
  localparam int CPSR_Z = 30;
  localparam int CPSR_C = 29;
  localparam int CPSR_V = 28;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant logic: round-robin on ties, or port 0 always wins when
// FIXED_PRIO is set. last_grant only moves when a grant is actually taken.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic update,
  output logic grant,
  output logic any
);

  logic last_grant;

  always_comb begin
    any = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = FIXED_PRIO ? 1'b0 : ~last_grant;
    end else begin
      grant = valid1;
    end
  end

  // Resetting to 1 lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (update && any) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one EXE/ALU datapath between pipeline issue (port 0) and the
// AGU/debug unit (port 1); returns results on a valid/ready channel and owns CPSR.
module alu_arbiter
  import exe_pkg::*;
#(
  parameter logic [31:0] CPSR_RESET = 32'h0000_0000,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_reg1,
  input  logic [31:0] req0_reg2,
  input  logic [31:0] req0_imm,
  input  logic [2:0]  req0_oc,
  input  logic        req0_ir_op,
  input  logic        req0_setf,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_reg1,
  input  logic [31:0] req1_reg2,
  input  logic [31:0] req1_imm,
  input  logic [2:0]  req1_oc,
  input  logic        req1_ir_op,
  input  logic        req1_setf,
  output logic [31:0] exe_reg1_val,
  output logic [31:0] exe_reg2_val,
  output logic [31:0] exe_immediate,
  output logic [2:0]  exe_alu_oc,
  output logic        exe_ir_op,
  input  logic [32:0] exe_result,
  input  logic [31:0] exe_cpsr_val,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [32:0] rsp_result,
  output logic [31:0] cpsr,
  output logic        busy
);

  state_t state_reg, state_next;
  logic   accept_ok;
  logic   accept;
  logic   grant;
  logic   grant_any;
  logic   setf_reg;
  logic   id_reg;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .update (accept),
    .grant  (grant),
    .any    (grant_any)
  );

  // A new op may enter while the previous response is being consumed.
  assign accept_ok  = (state_reg == IDLE) || ((state_reg == RESP) && rsp_ready);
  assign accept     = accept_ok && grant_any;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_comb begin
    state_next = state_reg;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = accept ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Operand latch: exe_* hold their last values until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_reg1_val  <= '0;
      exe_reg2_val  <= '0;
      exe_immediate <= '0;
      exe_alu_oc    <= '0;
      exe_ir_op     <= 1'b0;
      setf_reg      <= 1'b0;
      id_reg        <= 1'b0;
    end else if (accept) begin
      exe_reg1_val  <= grant ? req1_reg1  : req0_reg1;
      exe_reg2_val  <= grant ? req1_reg2  : req0_reg2;
      exe_immediate <= grant ? req1_imm   : req0_imm;
      exe_alu_oc    <= grant ? req1_oc    : req0_oc;
      exe_ir_op     <= grant ? req1_ir_op : req0_ir_op;
      setf_reg      <= grant ? req1_setf  : req0_setf;
      id_reg        <= grant;
    end
  end

  // Result capture and flag writeback happen on the single EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_id     <= 1'b0;
      cpsr       <= CPSR_RESET;
    end else if (state_reg == EXEC) begin
      rsp_result <= exe_result;
      rsp_id     <= id_reg;
      if (setf_reg) begin
        cpsr[CPSR_N:CPSR_V] <= exe_cpsr_val[CPSR_N:CPSR_V];
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural EXE model: a vector table
// of single ops, then contention, backpressure and mid-op reset sequences.
module tb_alu_arbiter;
  import exe_pkg::*;

  localparam logic [31:0] CPSR_RST = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_ir_op, req0_setf;
  logic [31:0] req0_reg1, req0_reg2, req0_imm;
  logic [2:0]  req0_oc;
  logic        req1_valid, req1_ready, req1_ir_op, req1_setf;
  logic [31:0] req1_reg1, req1_reg2, req1_imm;
  logic [2:0]  req1_oc;
  logic [31:0] exe_reg1_val, exe_reg2_val, exe_immediate, exe_cpsr_val;
  logic [2:0]  exe_alu_oc;
  logic        exe_ir_op;
  logic [32:0] exe_result;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [32:0] rsp_result;
  logic [31:0] cpsr;

  int checks = 0;
  int errors = 0;
  logic [3:0] flags_now;

  always #5 clk = ~clk;

  alu_arbiter #(.CPSR_RESET(CPSR_RST), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg1(req0_reg1),
    .req0_reg2(req0_reg2), .req0_imm(req0_imm), .req0_oc(req0_oc),
    .req0_ir_op(req0_ir_op), .req0_setf(req0_setf),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg1(req1_reg1),
    .req1_reg2(req1_reg2), .req1_imm(req1_imm), .req1_oc(req1_oc),
    .req1_ir_op(req1_ir_op), .req1_setf(req1_setf),
    .exe_reg1_val(exe_reg1_val), .exe_reg2_val(exe_reg2_val),
    .exe_immediate(exe_immediate), .exe_alu_oc(exe_alu_oc), .exe_ir_op(exe_ir_op),
    .exe_result(exe_result), .exe_cpsr_val(exe_cpsr_val),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .cpsr(cpsr), .busy(busy)
  );

  // Behavioural EXE: combinational from the exe_* operands. The low 28 flag
  // bits are driven to ones so any over-wide CPSR write shows up.
  logic [31:0] m_b;
  logic [32:0] m_sum;
  logic        m_v;
  always_comb begin
    m_b   = exe_ir_op ? exe_reg2_val : exe_immediate;
    m_sum = '0;
    m_v   = 1'b0;
    case (exe_alu_oc)
      ALU_ADD: begin
        m_sum = {1'b0, exe_reg1_val} + {1'b0, m_b};
        m_v   = (exe_reg1_val[31] == m_b[31]) && (m_sum[31] != exe_reg1_val[31]);
      end
      ALU_SUB: begin
        m_sum = {1'b0, exe_reg1_val} + {1'b0, ~m_b} + 33'd1;
        m_v   = (exe_reg1_val[31] != m_b[31]) && (m_sum[31] != exe_reg1_val[31]);
      end
      ALU_AND: m_sum = {1'b0, exe_reg1_val & m_b};
      ALU_ORR: m_sum = {1'b0, exe_reg1_val | m_b};
      ALU_EOR: m_sum = {1'b0, exe_reg1_val ^ m_b};
      ALU_MOV: m_sum = {1'b0, m_b};
      ALU_MVN: m_sum = {1'b0, ~m_b};
      default: m_sum = '0;
    endcase
    exe_result   = m_sum;
    exe_cpsr_val = {m_sum[31], (m_sum[31:0] == 32'd0), m_sum[32], m_v, 28'hFFF_FFFF};
  end

  typedef struct packed {
    logic        port;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] imm;
    logic [2:0]  oc;
    logic        ir;
    logic        setf;
    logic [32:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if (v.port) begin
      req1_reg1 = v.reg1; req1_reg2 = v.reg2; req1_imm = v.imm;
      req1_oc = v.oc; req1_ir_op = v.ir; req1_setf = v.setf; req1_valid = 1'b1;
    end else begin
      req0_reg1 = v.reg1; req0_reg2 = v.reg2; req0_imm = v.imm;
      req0_oc = v.oc; req0_ir_op = v.ir; req0_setf = v.setf; req0_valid = 1'b1;
    end
  endtask

  // One op through IDLE -> EXEC -> RESP, checking grant, latency and result.
  task automatic do_op(input vec_t v, input string tag);
    int cyc;
    bit got;
    drive(v);
    rsp_ready = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 10) begin
      @(negedge clk);
      cyc++;
      got = v.port ? req1_ready : req0_ready;
    end
    chk({tag, "_grant_cycle"}, cyc, 1);
    chk({tag, "_other_ready"}, v.port ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    if (v.port) req1_valid = 1'b0; else req0_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_exec_busy"}, busy, 1);
    chk({tag, "_exec_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_exec_operand"}, exe_reg1_val, v.reg1);
    chk({tag, "_exec_cpsr"}, cpsr, {flags_now, CPSR_RST[27:0]});
    @(negedge clk);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_result"}, rsp_result, v.res);
    chk({tag, "_rsp_id"}, rsp_id, v.port);
    chk({tag, "_cpsr"}, cpsr, {v.flags, CPSR_RST[27:0]});
    flags_now = v.flags;
    $display("op %s port=%0d result=%h cpsr=%h", tag, v.port, rsp_result, cpsr);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int ng, nr;
    logic [32:0] held;
    vec_t bv;

    vecs[0] = '{1'b0, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b1, 1'b1, 33'd12, 4'b0000};
    vecs[1] = '{1'b1, 32'd0, 32'hDEAD_BEEF, 32'd0, ALU_ADD, 1'b0, 1'b1, 33'd0, 4'b0100};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, ALU_ADD, 1'b1, 1'b1, 33'h1_0000_0000, 4'b0110};
    vecs[3] = '{1'b1, 32'h7FFF_FFFF, 32'd0, 32'd1, ALU_ADD, 1'b0, 1'b1, 33'h0_8000_0000, 4'b1001};
    vecs[4] = '{1'b0, 32'd3, 32'd5, 32'd0, ALU_SUB, 1'b1, 1'b1, 33'h0_FFFF_FFFE, 4'b1000};
    vecs[5] = '{1'b0, 32'd5, 32'd3, 32'd0, ALU_SUB, 1'b1, 1'b0, 33'h1_0000_0002, 4'b1000};
    vecs[6] = '{1'b1, 32'h0000_F0F0, 32'd0, 32'h0000_0FF0, ALU_AND, 1'b0, 1'b1, 33'h0_0000_00F0, 4'b0000};
    vecs[7] = '{1'b0, 32'd0, 32'hFFFF_0000, 32'h0000_FFFF, ALU_ORR, 1'b0, 1'b1, 33'h0_0000_FFFF, 4'b0000};
    vecs[8] = '{1'b1, 32'h5555_AAAA, 32'hFFFF_FFFF, 32'd0, ALU_EOR, 1'b1, 1'b1, 33'h0_AAAA_5555, 4'b1000};

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_reg1 = '0; req0_reg2 = '0; req0_imm = '0;
    req0_oc = '0; req0_ir_op = 1'b0; req0_setf = 1'b0;
    req1_valid = 1'b0; req1_reg1 = '0; req1_reg2 = '0; req1_imm = '0;
    req1_oc = '0; req1_ir_op = 1'b0; req1_setf = 1'b0;
    flags_now = CPSR_RST[31:28];
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_cpsr", cpsr, CPSR_RST);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_busy", busy, 0);
    chk("reset_exe", {exe_reg1_val, exe_alu_oc, exe_ir_op}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Contention: both ports valid continuously, back-to-back responses.
    req0_reg1 = 32'd100; req0_reg2 = 32'd1; req0_oc = ALU_ADD; req0_ir_op = 1'b1; req0_setf = 1'b0;
    req1_reg1 = 32'd200; req1_reg2 = 32'd2; req1_oc = ALU_ADD; req1_ir_op = 1'b1; req1_setf = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && nr < 4; c++) begin
      @(negedge clk);
      if (rsp_valid && nr < 4) begin
        chk($sformatf("cont_rsp%0d_id", nr), rsp_id, nr % 2);
        chk($sformatf("cont_rsp%0d_result", nr), rsp_result, (nr % 2) ? 33'd202 : 33'd101);
        $display("contention rsp %0d id=%0d result=%0d", nr, rsp_id, rsp_result);
        nr++;
      end
      if ((req0_ready || req1_ready) && ng < 4) begin
        chk($sformatf("cont_grant%0d", ng), {req1_ready, req0_ready}, (ng % 2) ? 2'b10 : 2'b01);
        ng++;
      end
      @(posedge clk); #1;
      if (ng == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    chk("cont_rsp_count", nr, 4);
    rsp_ready = 1'b0;

    // Backpressure with a non-flag-setting op and a waiting port 1 request.
    req0_reg1 = 32'd9; req0_reg2 = 32'd4; req0_oc = ALU_SUB; req0_ir_op = 1'b1; req0_setf = 1'b0;
    req1_reg1 = 32'd1; req1_reg2 = 32'd1; req1_oc = ALU_ADD; req1_ir_op = 1'b1; req1_setf = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("bp_grant0", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_result", rsp_result, 33'h1_0000_0005);
    chk("bp_rsp_id", rsp_id, 0);
    chk("bp_cpsr_gated", cpsr, {flags_now, CPSR_RST[27:0]});
    held = rsp_result;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_state", c), {rsp_valid, busy, req1_ready, req0_ready}, 4'b1100);
      chk($sformatf("bp%0d_result", c), rsp_result, held);
      chk($sformatf("bp%0d_exe_hold", c), exe_reg1_val, 32'd9);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_b2b_ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_b2b_exec", {rsp_valid, busy}, 2'b01);
    @(negedge clk);
    chk("bp_b2b_result", rsp_result, 33'd2);
    chk("bp_b2b_id", rsp_id, 1);
    chk("bp_b2b_cpsr", cpsr, {4'b0000, CPSR_RST[27:0]});
    flags_now = 4'b0000;
    $display("backpressure done result=%h cpsr=%h", rsp_result, cpsr);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during EXEC of a flag-setting op that would set Z.
    bv = '{1'b1, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 33'd0, 4'b0100};
    drive(bv);
    @(negedge clk);
    chk("rst_pre_grant", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_state", {rsp_valid, busy}, 2'b00);
    chk("rst_async_cpsr", cpsr, CPSR_RST);
    @(posedge clk); #1;
    chk("rst_hold_cpsr", cpsr, CPSR_RST);
    rst_n = 1'b1;
    flags_now = CPSR_RST[31:28];
    req1_reg1 = 32'd1; req1_reg2 = 32'd1; req1_oc = ALU_ADD; req1_ir_op = 1'b1; req1_setf = 1'b0;
    req1_valid = 1'b1;
    bv = '{1'b0, 32'd40, 32'd2, 32'd0, ALU_ADD, 1'b1, 1'b0, 33'd42, CPSR_RST[31:28]};
    do_op(bv, "post_rst");
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
